led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
// PURPOSE
//  Multi-channel LED driver; successor to the single-rate fixed blinker.
//  Each channel has its own runtime-programmed mode: OFF, ON, BLINK with its own half-period, or DIM (PWM brightness).
//  Sits between board-level control logic (config writes over a valid/ready port) and the LED pins.
//  All channels share one tick prescaler so that they stay phase-related.
// PARAMETERS
//  CLOCK_HZ        24_000_000  input clock frequency
//  TICK_HZ         1_000       blink time base; TICK_DIV = CLOCK_HZ/TICK_HZ, elaboration error if < 1
//  NUMBER_OF_LEDS  8           channel count, >= 1
//  PERIOD_BITS     16          width of the blink half-period, in ticks
//  DUTY_BITS       8           PWM resolution
// PORTS
//  clock        in   1                  sole clock, rising edge
//  reset_n      in   1                  asynchronous, active-low reset
//  cfg_valid    in   1                  config write request
//  cfg_ready    out  1                  config write accepted when cfg_valid & cfg_ready
//  cfg_channel  in   max(1,$clog2(N))   target channel
//  cfg_mode     in   2                  0 OFF, 1 ON, 2 BLINK, 3 DIM
//  cfg_period   in   PERIOD_BITS        BLINK half-period, in ticks
//  cfg_duty     in   DUTY_BITS          DIM on-count, out of 2**DUTY_BITS
//  sync_pulse   in   1                  restart all blink phases and the prescaler
//  led_out      out  NUMBER_OF_LEDS     registered LED drive, 1 = lit
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all modes OFF; period, duty, counters, prescaler and PWM counter 0; all phase bits 1
//   - led_out 0; cfg_ready 0
//   - cfg_ready goes to 1 on the first clock edge after reset_n deasserts and then stays 1
//   - Mid-operation reset: the same clear, immediately; no config survives
//  Prescaler:
//   - counts 0..TICK_DIV-1 and wraps; tick is a 1-cycle pulse in the cycle the count equals TICK_DIV-1
//   - TICK_DIV == 1: tick is high every cycle
//  PWM counter: free-running DUTY_BITS counter, +1 every clock, wraps naturally.
//  Config:
//   - on accept (edge k), the channel's mode, period and duty are loaded; its counter clears to 0; its phase is set to 1
//   - led_out shows the new mode from edge k+1
//   - cfg_channel >= NUMBER_OF_LEDS: accepted (handshake completes) with no state change
//  BLINK, per channel, on each tick:
//   - P = max(period,1)
//   - counter == P-1: counter <= 0 and phase toggles; otherwise counter++
//   - Result: lit P ticks, then dark P ticks. period 0 behaves as 1.
//   - Counters advance only in BLINK mode; in other modes they hold.
//  led_out[i] is registered from the current state:
//   - OFF -> 0
//   - ON -> 1
//   - BLINK -> phase
//   - DIM -> (pwm_cnt < duty): duty 0 always dark; duty 2**DUTY_BITS-1 dark 1 cycle per PWM frame
//  sync_pulse, on edge k:
//   - prescaler and all channel counters <= 0; all phases <= 1
//   - has priority over a tick in the same cycle
//   - simultaneous with a config accept: the config write applies and the sync clear also applies; the result is identical
//  Arithmetic: all counters are unsigned and wrap modulo their width. No saturation other than the P = max(period,1) rule.
// TESTING (CLOCK_HZ=8, TICK_HZ=2 -> TICK_DIV=4; N=4; PERIOD_BITS=4; DUTY_BITS=3)
//  1 Reset
//    - stimulus: hold reset_n low, then release
//    - required: led_out = 0 while low; cfg_ready = 1 exactly one edge after release; all LEDs stay 0 with no config
//  2 BLINK, period 3 on channel 1
//    - required: led_out[1] lit 12 cycles, dark 12 cycles, repeating; other bits stay 0
//  3 DIM, duty 2 on channel 0
//    - required: led_out[0] high exactly 2 of every 8 cycles
//    - duty 0: never high
//    - duty 7: high 7 of every 8 cycles
//  4 BLINK with period 0
//    - required: toggles every tick (4 cycles)
//  5 Write to cfg_channel 5
//    - required: handshake completes; led_out and all state unchanged
//  6 Sync and reset during BLINK
//    - stimulus: BLINK on channels 2 and 3 with different periods; sync_pulse in the same cycle as a config write to channel 2
//    - required: both channels restart lit; the next toggle comes after P*4 cycles
//    - then: assert reset_n mid-blink -> led_out drops to 0 at once; all modes return to OFF

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Multi-channel LED driver. Every channel is programmed at run time over a
//   valid/ready config port to one of OFF, ON, BLINK (own half-period, counted
//   in prescaler ticks) or DIM (PWM brightness). All channels share one tick
//   prescaler and one PWM counter so that their patterns stay phase-related.
//
// Ports
//   clock        in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset (release synchronised upstream)
//   cfg_valid    in   config write request
//   cfg_ready    out  write accepted when cfg_valid & cfg_ready
//   cfg_channel  in   target channel; out-of-range channels are accepted and ignored
//   cfg_mode     in   0 OFF, 1 ON, 2 BLINK, 3 DIM
//   cfg_period   in   BLINK half-period in ticks (0 behaves as 1)
//   cfg_duty     in   DIM on-count out of 2**DUTY_BITS
//   sync_pulse   in   restart all blink phases and the prescaler
//   led_out      out  registered LED drive, 1 = lit
module led_pattern_gen #(
   parameter int  CLOCK_HZ       = 24_000_000,
   parameter int  TICK_HZ        = 1_000,
   parameter int  NUMBER_OF_LEDS = 8,
   parameter int  PERIOD_BITS    = 16,
   parameter int  DUTY_BITS      = 8,
   localparam int CH_W           = (NUMBER_OF_LEDS > 1) ? $clog2(NUMBER_OF_LEDS) : 1
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [CH_W-1:0]           cfg_channel,
   input  logic [1:0]                cfg_mode,
   input  logic [PERIOD_BITS-1:0]    cfg_period,
   input  logic [DUTY_BITS-1:0]      cfg_duty,
   input  logic                      sync_pulse,
   output logic [NUMBER_OF_LEDS-1:0] led_out
);

   localparam int TICK_DIV = CLOCK_HZ / TICK_HZ;
   localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   if (TICK_DIV < 1) begin : g_bad_tick_div
      $error("led_pattern_gen: CLOCK_HZ/TICK_HZ must be at least 1");
   end
   if (NUMBER_OF_LEDS < 1) begin : g_bad_led_count
      $error("led_pattern_gen: NUMBER_OF_LEDS must be at least 1");
   end

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_DIM   = 2'd3
   } mode_t;

   mode_t                  ch_mode   [NUMBER_OF_LEDS];
   logic [PERIOD_BITS-1:0] ch_period [NUMBER_OF_LEDS];
   logic [PERIOD_BITS-1:0] ch_cnt    [NUMBER_OF_LEDS];
   logic [DUTY_BITS-1:0]   ch_duty   [NUMBER_OF_LEDS];
   logic [NUMBER_OF_LEDS-1:0] ch_phase;

   logic [PRESC_W-1:0]        presc;
   logic [DUTY_BITS-1:0]      pwm_cnt;
   logic                      tick;
   logic                      accept;
   logic [NUMBER_OF_LEDS-1:0] led_next;

   // Last counter value of a half-period; a programmed period of 0 is
   // treated as 1 so the channel still toggles on every tick.
   function automatic logic [PERIOD_BITS-1:0] half_period_last(
      input logic [PERIOD_BITS-1:0] period
   );
      return (period == '0) ? '0 : period - PERIOD_BITS'(1);
   endfunction

   // With TICK_DIV == 1 the prescaler is stuck at 0 and tick is always high.
   assign tick   = (presc == PRESC_W'(TICK_DIV - 1));
   assign accept = cfg_valid & cfg_ready;

   always_comb begin
      led_next = '0;
      for (int i = 0; i < NUMBER_OF_LEDS; i++) begin
         case (ch_mode[i])
            MODE_OFF:   led_next[i] = 1'b0;
            MODE_ON:    led_next[i] = 1'b1;
            MODE_BLINK: led_next[i] = ch_phase[i];
            MODE_DIM:   led_next[i] = (pwm_cnt < ch_duty[i]);
            default:    led_next[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cfg_ready <= 1'b0;
         presc     <= '0;
         pwm_cnt   <= '0;
         ch_phase  <= '1;
         led_out   <= '0;
         for (int i = 0; i < NUMBER_OF_LEDS; i++) begin
            ch_mode[i]   <= MODE_OFF;
            ch_period[i] <= '0;
            ch_duty[i]   <= '0;
            ch_cnt[i]    <= '0;
         end
      end else begin
         cfg_ready <= 1'b1;
         pwm_cnt   <= pwm_cnt + DUTY_BITS'(1);
         led_out   <= led_next;

         // sync_pulse wins over the wrap so all channels restart together.
         if (sync_pulse || tick) begin
            presc <= '0;
         end else begin
            presc <= presc + PRESC_W'(1);
         end

         // A config write and a sync both leave the channel at counter 0,
         // phase 1, so their coincidence needs no special ordering.
         for (int i = 0; i < NUMBER_OF_LEDS; i++) begin
            if (accept && (cfg_channel == CH_W'(i))) begin
               ch_mode[i]   <= mode_t'(cfg_mode);
               ch_period[i] <= cfg_period;
               ch_duty[i]   <= cfg_duty;
               ch_cnt[i]    <= '0;
               ch_phase[i]  <= 1'b1;
            end else if (sync_pulse) begin
               ch_cnt[i]    <= '0;
               ch_phase[i]  <= 1'b1;
            end else if (tick && (ch_mode[i] == MODE_BLINK)) begin
               if (ch_cnt[i] == half_period_last(ch_period[i])) begin
                  ch_cnt[i]   <= '0;
                  ch_phase[i] <= ~ch_phase[i];
               end else begin
                  ch_cnt[i]   <= ch_cnt[i] + PERIOD_BITS'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen
//   Directed bench for led_pattern_gen with an 8 Hz clock and 2 Hz tick
//   (TICK_DIV = 4), four 4-bit-period / 3-bit-duty channels, plus a second
//   five-channel instance used for the out-of-range channel write.
module tb_led_pattern_gen;

   localparam int PB = 4;
   localparam int DB = 3;

   logic          clock;
   logic          reset_n;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [1:0]    cfg_channel;
   logic [1:0]    cfg_mode;
   logic [PB-1:0] cfg_period;
   logic [DB-1:0] cfg_duty;
   logic          sync_pulse;
   logic [3:0]    led_out;

   logic          cfg_valid_b;
   logic          cfg_ready_b;
   logic [2:0]    cfg_channel_b;
   logic [4:0]    led_out_b;

   int total;
   int bad;

   led_pattern_gen #(
      .CLOCK_HZ(8), .TICK_HZ(2), .NUMBER_OF_LEDS(4), .PERIOD_BITS(PB), .DUTY_BITS(DB)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_channel(cfg_channel),
      .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
      .sync_pulse(sync_pulse), .led_out(led_out)
   );

   led_pattern_gen #(
      .CLOCK_HZ(8), .TICK_HZ(2), .NUMBER_OF_LEDS(5), .PERIOD_BITS(PB), .DUTY_BITS(DB)
   ) dut_b (
      .clock(clock), .reset_n(reset_n),
      .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b), .cfg_channel(cfg_channel_b),
      .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
      .sync_pulse(sync_pulse), .led_out(led_out_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]    chan;
      logic [1:0]    mode;
      logic [PB-1:0] period;
      logic [DB-1:0] duty;
      bit            exact;    // 1: compare 24-sample pattern, 0: compare high count
      logic [23:0]   pattern;  // bit j = expected LED level in sample j+1 after the write
      int            count;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      cfg_valid   = 1'b0;
      cfg_valid_b = 1'b0;
      sync_pulse  = 1'b0;
      reset_n     = 1'b0;
      repeat (2) tick_cycle();
      reset_n = 1'b1;
      tick_cycle();
   endtask

   task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode,
                            input logic [PB-1:0] period, input logic [DB-1:0] duty,
                            input logic sync);
      cfg_channel = ch;
      cfg_mode    = mode;
      cfg_period  = period;
      cfg_duty    = duty;
      cfg_valid   = 1'b1;
      sync_pulse  = sync;
      @(posedge clock);
      #1;
      cfg_valid  = 1'b0;
      sync_pulse = 1'b0;
   endtask

   initial begin
      logic [23:0] act_pat;
      logic [3:0]  exp4;
      int          others;
      int          cnt;
      int          run;
      bit          found;
      bit          done;
      int          nonzero;

      total = 0;
      bad   = 0;

      vecs[0]  = '{2'd0, 2'd0, 4'd0,  3'd0, 1'b1, 24'h000000, 0};   // OFF
      vecs[1]  = '{2'd1, 2'd1, 4'd0,  3'd0, 1'b1, 24'hFFFFFF, 0};   // ON
      vecs[2]  = '{2'd1, 2'd2, 4'd3,  3'd0, 1'b1, 24'h000FFF, 0};   // BLINK P=3
      vecs[3]  = '{2'd2, 2'd2, 4'd0,  3'd0, 1'b1, 24'h0F0F0F, 0};   // BLINK period 0 -> 1
      vecs[4]  = '{2'd3, 2'd2, 4'd1,  3'd0, 1'b1, 24'h0F0F0F, 0};   // BLINK P=1
      vecs[5]  = '{2'd0, 2'd2, 4'd2,  3'd0, 1'b1, 24'hFF00FF, 0};   // BLINK P=2
      vecs[6]  = '{2'd0, 2'd3, 4'd0,  3'd2, 1'b0, 24'h000000, 6};   // DIM duty 2
      vecs[7]  = '{2'd0, 2'd3, 4'd0,  3'd0, 1'b0, 24'h000000, 0};   // DIM duty 0
      vecs[8]  = '{2'd0, 2'd3, 4'd0,  3'd7, 1'b0, 24'h000000, 21};  // DIM duty max
      vecs[9]  = '{2'd3, 2'd3, 4'd0,  3'd4, 1'b0, 24'h000000, 12};  // DIM duty 4
      vecs[10] = '{2'd2, 2'd2, 4'd15, 3'd0, 1'b1, 24'hFFFFFF, 0};   // BLINK max period

      cfg_valid     = 1'b0;
      cfg_channel   = '0;
      cfg_mode      = '0;
      cfg_period    = '0;
      cfg_duty      = '0;
      sync_pulse    = 1'b0;
      cfg_valid_b   = 1'b0;
      cfg_channel_b = '0;
      reset_n       = 1'b0;

      // Reset: outputs held low, ready one edge after release, idle stays dark.
      repeat (3) tick_cycle();
      check("reset led_out", led_out, 4'h0);
      check("reset cfg_ready", cfg_ready, 1'b0);
      reset_n = 1'b1;
      #1;
      check("ready before first edge", cfg_ready, 1'b0);
      tick_cycle();
      check("ready after first edge", cfg_ready, 1'b1);
      nonzero = 0;
      for (int c = 0; c < 20; c++) begin
         tick_cycle();
         if (led_out != 4'h0 || cfg_ready != 1'b1) nonzero++;
      end
      check("idle leds dark", nonzero, 0);

      // Table: write with sync so the prescaler phase is known, then observe 24 cycles.
      for (int v = 0; v < 11; v++) begin
         do_reset();
         cfg_write(vecs[v].chan, vecs[v].mode, vecs[v].period, vecs[v].duty, 1'b1);
         act_pat = '0;
         others  = 0;
         cnt     = 0;
         for (int s = 0; s < 24; s++) begin
            tick_cycle();
            act_pat[s] = led_out[vecs[v].chan];
            if (led_out[vecs[v].chan]) cnt++;
            if ((led_out & ~(4'b0001 << vecs[v].chan)) != 4'h0) others++;
         end
         if (vecs[v].exact)
            check($sformatf("vec%0d pattern", v), act_pat, vecs[v].pattern);
         else
            check($sformatf("vec%0d high count", v), cnt, vecs[v].count);
         check($sformatf("vec%0d other channels", v), others, 0);
      end

      // BLINK period 3 on channel 1 without sync: steady-state run lengths.
      do_reset();
      cfg_write(2'd1, 2'd2, 4'd3, 3'd0, 1'b0);
      tick_cycle();
      check("blink starts lit", led_out, 4'b0010);
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         tick_cycle();
         if (!led_out[1]) found = 1'b1;
      end
      check("blink falls", found, 1'b1);
      run = 1;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         tick_cycle();
         if (led_out[1]) done = 1'b1;
         else run++;
      end
      check("blink dark run", run, 12);
      run = 1;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         tick_cycle();
         if (!led_out[1]) done = 1'b1;
         else run++;
      end
      check("blink lit run", run, 12);

      // Sync coinciding with a config write while another channel blinks.
      do_reset();
      cfg_write(2'd3, 2'd2, 4'd2, 3'd0, 1'b0);
      repeat (5) tick_cycle();
      cfg_write(2'd2, 2'd2, 4'd3, 3'd0, 1'b1);
      for (int s = 1; s <= 16; s++) begin
         tick_cycle();
         exp4 = {(s <= 8) ? 1'b1 : 1'b0, (s <= 12) ? 1'b1 : 1'b0, 2'b00};
         check($sformatf("sync restart s%0d", s), led_out, exp4);
      end

      // Mid-blink reset drops outputs at once and clears all config.
      #2;
      reset_n = 1'b0;
      #1;
      check("async reset led_out", led_out, 4'h0);
      check("async reset cfg_ready", cfg_ready, 1'b0);
      tick_cycle();
      reset_n = 1'b1;
      tick_cycle();
      check("ready after mid reset", cfg_ready, 1'b1);
      nonzero = 0;
      for (int c = 0; c < 30; c++) begin
         tick_cycle();
         if (led_out != 4'h0) nonzero++;
      end
      check("modes cleared by reset", nonzero, 0);

      // Out-of-range channel on the five-channel instance.
      do_reset();
      cfg_channel_b = 3'd0;
      cfg_mode      = 2'd1;
      cfg_period    = '0;
      cfg_duty      = '0;
      cfg_valid_b   = 1'b1;
      tick_cycle();
      cfg_valid_b   = 1'b0;
      tick_cycle();
      check("b channel0 on", led_out_b, 5'b00001);
      cfg_channel_b = 3'd5;
      cfg_mode      = 2'd0;
      cfg_valid_b   = 1'b1;
      check("b ready for ch5 write", cfg_ready_b, 1'b1);
      tick_cycle();
      cfg_valid_b   = 1'b0;
      nonzero = 0;
      for (int c = 0; c < 10; c++) begin
         tick_cycle();
         if (led_out_b != 5'b00001 || cfg_ready_b != 1'b1) nonzero++;
      end
      check("b ch5 write no effect", nonzero, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
